seq_divider: RTL

//   Multi-cycle restoring divider, parametrised in width and radix, with
//   per-operation signed/unsigned mode and a start/busy/done handshake.
//   It sits in the ALU's DIV slot. result drives the HI/LO register pair:
//   HI = remainder, LO = quotient.
//   One operation is in flight at a time. The result is held until the next start.

---
 rtl/seq_divider.sv | 107 ++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider with per-operation signed mode.
// result = {remainder, quotient}; start/busy/done handshake, result held until next FIX.
module seq_divider #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 1,
    parameter bit SIGNED_EN  = 1
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] result
);
    localparam int N  = WIDTH / RADIX_BITS;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, next_state;
    logic [WIDTH:0]   a, a_n;
    logic [WIDTH-1:0] q, q_n, m;
    logic [WIDTH+1:0] t;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, dz;
    logic             sgn, neg_d, neg_v, zero_v;
    logic [WIDTH-1:0] mag_d, mag_v, fix_r, fix_q;

    assign sgn    = SIGNED_EN && signed_op;
    assign neg_d  = sgn & dividend[WIDTH-1];
    assign neg_v  = sgn & divisor[WIDTH-1];
    assign mag_d  = neg_d ? -dividend : dividend;
    assign mag_v  = neg_v ? -divisor : divisor;
    assign zero_v = divisor == '0;
    assign busy   = state != IDLE;
    assign fix_r  = neg_r ? -a[WIDTH-1:0] : a[WIDTH-1:0];
    assign fix_q  = neg_q ? -q : q;

    // RADIX_BITS restoring steps per clock; the extra top bit of t is the borrow
    always_comb begin
        a_n = a;
        q_n = q;
        t   = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            a_n = {a_n[WIDTH-1:0], q_n[WIDTH-1]};
            q_n = {q_n[WIDTH-2:0], 1'b0};
            t   = {1'b0, a_n} - {2'b00, m};
            if (!t[WIDTH+1]) begin
                a_n    = t[WIDTH:0];
                q_n[0] = 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? (zero_v ? FIX : CALC) : IDLE;
            CALC:    next_state = cnt == '0 ? FIX : CALC;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            a           <= '0;
            q           <= '0;
            m           <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            result      <= '0;
        end else begin
            done <= state == FIX;
            if (state == IDLE && start) begin
                // a zero divisor keeps the raw dividend in q so FIX can return it unchanged
                a           <= '0;
                q           <= zero_v ? dividend : mag_d;
                m           <= mag_v;
                cnt         <= CW'(N - 1);
                neg_q       <= neg_d ^ neg_v;
                neg_r       <= neg_d;
                dz          <= zero_v;
                div_by_zero <= 1'b0;
            end else if (state == CALC) begin
                a   <= a_n;
                q   <= q_n;
                cnt <= cnt - 1'b1;
            end else if (state == FIX) begin
                result      <= dz ? {q, {WIDTH{1'b1}}} : {fix_r, fix_q};
                div_by_zero <= dz;
            end
        end
    end
endmodule
